// File: rtl/lsram_arb_pkg.sv
// Shared definitions for the large-SRAM port arbiter: FSM state encoding,
// HSIZE constants and default widths.
package lsram_arb_pkg;

    localparam int unsigned DEF_AHB_DWIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 20;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssueA = 3'd1,
        StWaitA  = 3'd2,
        StIssueB = 3'd3,
        StWaitB  = 3'd4
    } arb_state_e;

    // True while port B owns the SRAM command port.
    function automatic logic is_b_state(arb_state_e s);
        return (s == StIssueB) || (s == StWaitB);
    endfunction

endpackage

// File: rtl/lsram_arb_cmd_hold.sv
// Per-port command holding register: captures a request pulse, keeps it
// pending until the port's ack, and flags (sticky) any pulse that arrives
// while the port still has an outstanding request.
module lsram_arb_cmd_hold
    import lsram_arb_pkg::*;
#(
    parameter int unsigned AHB_DWIDTH = DEF_AHB_DWIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  req,
    input  logic                  write,
    input  logic [2:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [AHB_DWIDTH-1:0] wdata,
    input  logic                  done,
    output logic                  pending,
    output logic                  pending_nxt,
    output logic                  h_write,
    output logic [2:0]            h_size,
    output logic [ADDR_WIDTH-1:0] h_addr,
    output logic [AHB_DWIDTH-1:0] h_wdata,
    output logic                  err
);

    logic                  pending_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [AHB_DWIDTH-1:0] wdata_q;
    logic                  err_q;
    logic                  capture;

    // Pending covers both "waiting for grant" and "in service".
    assign capture     = req & ~pending_q;
    assign pending_nxt = (pending_q & ~done) | capture;

    // Holding register, pending flag and sticky protocol-error flag.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            pending_q <= 1'b0;
            write_q   <= 1'b0;
            size_q    <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_nxt;
            if (capture) begin
                write_q <= write;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (req && pending_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pending = pending_q;
    assign h_write = write_q;
    assign h_size  = size_q;
    assign h_addr  = addr_q;
    assign h_wdata = wdata_q;
    assign err     = err_q;

endmodule

// File: rtl/lsram_port_arbiter.sv
// Two-port arbiter in front of the large-SRAM command port. Port A is the
// AHB slave side, port B the DM waveform/DMA engine. BUSY tells the AHB side
// that port B owns or is waiting for the SRAM.
// Optional build macro LSRAM_ARB_ROUND_ROBIN_EN: resolve simultaneous pending
// requests with a 1-bit round-robin pointer instead of fixed B_PRIORITY.
module lsram_port_arbiter
    import lsram_arb_pkg::*;
#(
    parameter int unsigned AHB_DWIDTH = DEF_AHB_DWIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned B_PRIORITY = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [2:0]            a_size,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [AHB_DWIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [AHB_DWIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [2:0]            b_size,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [AHB_DWIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [AHB_DWIDTH-1:0] b_rdata,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [AHB_DWIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [AHB_DWIDTH-1:0] mem_rdata,
    output logic                  BUSY,
    output logic                  proto_err
);

    arb_state_e            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  pend_a, pend_a_nxt, pend_b, pend_b_nxt;
    logic                  err_a, err_b;
    logic                  hw_a, hw_b;
    logic [2:0]            hs_a, hs_b;
    logic [ADDR_WIDTH-1:0] ha_a, ha_b;
    logic [AHB_DWIDTH-1:0] hd_a, hd_b;
    logic                  want_a, want_b, pick_b;

    lsram_arb_cmd_hold #(
        .AHB_DWIDTH (AHB_DWIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold_a (
        .HCLK        (HCLK),
        .HRESETN     (HRESETN),
        .req         (a_req),
        .write       (a_write),
        .size        (a_size),
        .addr        (a_addr),
        .wdata       (a_wdata),
        .done        (a_ack),
        .pending     (pend_a),
        .pending_nxt (pend_a_nxt),
        .h_write     (hw_a),
        .h_size      (hs_a),
        .h_addr      (ha_a),
        .h_wdata     (hd_a),
        .err         (err_a)
    );

    lsram_arb_cmd_hold #(
        .AHB_DWIDTH (AHB_DWIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold_b (
        .HCLK        (HCLK),
        .HRESETN     (HRESETN),
        .req         (b_req),
        .write       (b_write),
        .size        (b_size),
        .addr        (b_addr),
        .wdata       (b_wdata),
        .done        (b_ack),
        .pending     (pend_b),
        .pending_nxt (pend_b_nxt),
        .h_write     (hw_b),
        .h_size      (hs_b),
        .h_addr      (ha_b),
        .h_wdata     (hd_b),
        .err         (err_b)
    );

    // A same-cycle pulse counts so IDLE can grant without an extra cycle.
    assign want_a = pend_a | a_req;
    assign want_b = pend_b | b_req;

`ifdef LSRAM_ARB_ROUND_ROBIN_EN
    logic rr_q;  // 0: port A preferred on a tie, 1: port B preferred

    assign pick_b = want_b & (~want_a | rr_q);

    // Point at the other port after each completed grant.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            rr_q <= 1'b0;
        end else if (a_ack) begin
            rr_q <= 1'b1;
        end else if (b_ack) begin
            rr_q <= 1'b0;
        end
    end
`else
    assign pick_b = want_b & (~want_a | (B_PRIORITY != 0));
`endif

    // Next-state: grant from IDLE, one-cycle issue, wait for SRAM completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (want_a || want_b) begin
                    state_d = pick_b ? StIssueB : StIssueA;
                end
            end
            StIssueA: state_d = StWaitA;
            StWaitA:  if (mem_ack) state_d = StIdle;
            StIssueB: state_d = StWaitB;
            StWaitB:  if (mem_ack) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign busy_d = pend_b_nxt | is_b_state(state_d);

    // FSM state and registered BUSY.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // mem_ack outside WAIT_x is ignored by construction.
    assign a_ack   = (state_q == StWaitA) & mem_ack;
    assign b_ack   = (state_q == StWaitB) & mem_ack;
    assign a_rdata = a_ack ? mem_rdata : '0;
    assign b_rdata = b_ack ? mem_rdata : '0;
    assign mem_req = (state_q == StIssueA) | (state_q == StIssueB);

    // SRAM command fields come from the owner's holding register; 0 when idle.
    always_comb begin
        mem_write = 1'b0;
        mem_size  = 3'b000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == StIssueA || state_q == StWaitA) begin
            mem_write = hw_a;
            mem_size  = hs_a;
            mem_addr  = ha_a;
            mem_wdata = hd_a;
        end else if (is_b_state(state_q)) begin
            mem_write = hw_b;
            mem_size  = hs_b;
            mem_addr  = ha_b;
            mem_wdata = hd_b;
        end
    end

    assign BUSY      = busy_q;
    assign proto_err = err_a | err_b;

endmodule

// File: tb/tb_lsram_port_arbiter.sv
// Directed bench for lsram_port_arbiter (default build: fixed priority, B wins).
module tb_lsram_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 20;

    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    logic          a_req = 1'b0, a_write = 1'b0;
    logic [2:0]    a_size = 3'b000;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_ack;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_write = 1'b0;
    logic [2:0]    b_size = 3'b000;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    logic          mem_req, mem_write;
    logic [2:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          BUSY, proto_err;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [DW-1:0] rd_tab [64];

    lsram_port_arbiter #(
        .AHB_DWIDTH (DW),
        .ADDR_WIDTH (AW),
        .B_PRIORITY (1)
    ) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .a_req     (a_req),
        .a_write   (a_write),
        .a_size    (a_size),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_write   (b_write),
        .b_size    (b_size),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .BUSY      (BUSY),
        .proto_err (proto_err)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; all pulse inputs drop back to idle.
    task automatic tick();
        @(posedge HCLK);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_a(input logic w, input logic [2:0] sz, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd);
        a_req = 1'b1; a_write = w; a_size = sz; a_addr = ad; a_wdata = wd;
    endtask

    task automatic drive_b(input logic w, input logic [2:0] sz, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd);
        b_req = 1'b1; b_write = w; b_size = sz; b_addr = ad; b_wdata = wd;
    endtask

    function automatic logic [AW-1:0] rnd_addr(input int i);
        return AW'(32'h00300 + 32'(i) * 4);
    endfunction

    function automatic logic [DW-1:0] rnd_wdata(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic issue(input int i);
        if ((i % 2) == 0) drive_a(i[1], 3'b010, rnd_addr(i), rnd_wdata(i));
        else              drive_b(i[1], 3'b010, rnd_addr(i), rnd_wdata(i));
    endtask

    initial begin
        // Reset state
        settle();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_proto_err", proto_err, 0);
        check_eq("rst_acks", {a_ack, b_ack}, 0);
        tick();
        HRESETN = 1'b1;
        tick();

        // Port-A write, mem_ack 3 cycles after mem_req
        drive_a(1'b1, 3'b010, 20'h00010, 32'hDEADBEEF);
        settle();
        check_eq("t1_no_req_yet", mem_req, 0);
        tick(); settle();
        check_eq("t1_mem_req", mem_req, 1);
        check_eq("t1_mem_addr", mem_addr, 32'h00010);
        check_eq("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check_eq("t1_mem_write", mem_write, 1);
        check_eq("t1_mem_size", mem_size, 3'b010);
        tick(); settle();
        check_eq("t1_req_one_cycle", mem_req, 0);
        check_eq("t1_addr_stable", mem_addr, 32'h00010);
        check_eq("t1_busy", BUSY, 0);
        tick(); settle();
        check_eq("t1_no_early_ack", a_ack, 0);
        tick();
        mem_ack = 1'b1; settle();
        check_eq("t1_a_ack", a_ack, 1);
        check_eq("t1_b_ack", b_ack, 0);
        check_eq("t1_busy_end", BUSY, 0);
        tick(); settle();
        check_eq("t1_ack_pulse", a_ack, 0);

        // Port-B read
        tick();
        drive_b(1'b0, 3'b010, 20'hFFFFC, 32'h0);
        settle();
        check_eq("t2_busy_pre", BUSY, 0);
        tick(); settle();
        check_eq("t2_busy_rise", BUSY, 1);
        check_eq("t2_mem_req", mem_req, 1);
        check_eq("t2_mem_addr", mem_addr, 32'hFFFFC);
        check_eq("t2_mem_write", mem_write, 0);
        tick();
        mem_rdata = 32'hFFFF_FFFF; settle();
        check_eq("t2_rdata_gated", b_rdata, 0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678; settle();
        check_eq("t2_b_ack", b_ack, 1);
        check_eq("t2_b_rdata", b_rdata, 32'h12345678);
        check_eq("t2_a_ack", a_ack, 0);
        check_eq("t2_busy_at_ack", BUSY, 1);
        tick(); settle();
        check_eq("t2_busy_fall", BUSY, 0);

        // Simultaneous request: B first, then A
        tick();
        drive_a(1'b0, 3'b000, 20'h00100, 32'h0);
        drive_b(1'b1, 3'b001, 20'h00200, 32'h0000BEEF);
        tick(); settle();
        check_eq("t3_first_req", mem_req, 1);
        check_eq("t3_first_addr", mem_addr, 32'h00200);
        tick();
        mem_ack = 1'b1; settle();
        check_eq("t3_first_b_ack", b_ack, 1);
        check_eq("t3_first_no_a_ack", a_ack, 0);
        tick(); settle();
        check_eq("t3_idle_gap", mem_req, 0);
        tick(); settle();
        check_eq("t3_second_req", mem_req, 1);
        check_eq("t3_second_addr", mem_addr, 32'h00100);
        check_eq("t3_second_size", mem_size, 3'b000);
        check_eq("t3_busy_a", BUSY, 0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; settle();
        check_eq("t3_second_a_ack", a_ack, 1);
        check_eq("t3_second_a_rdata", a_rdata, 32'h0BAD_F00D);
        tick();

        // Second a_req while in WAIT_A is dropped
        drive_a(1'b1, 3'b010, 20'h00040, 32'h1111_1111);
        tick(); settle();
        check_eq("t4_mem_req", mem_req, 1);
        tick();
        drive_a(1'b1, 3'b010, 20'h00080, 32'h2222_2222);
        tick(); settle();
        check_eq("t4_proto_err", proto_err, 1);
        check_eq("t4_addr_kept", mem_addr, 32'h00040);
        mem_ack = 1'b1; settle();
        check_eq("t4_a_ack", a_ack, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            check_eq("t4_no_second_grant", {mem_req, a_ack}, 0);
        end
        check_eq("t4_proto_err_sticky", proto_err, 1);

        // Reset during WAIT_B, stray mem_ack afterwards
        drive_b(1'b0, 3'b010, 20'h00500, 32'h0);
        tick(); tick(); settle();
        check_eq("t5_busy_before", BUSY, 1);
        HRESETN = 1'b0; settle();
        check_eq("t5_busy_in_rst", BUSY, 0);
        check_eq("t5_addr_in_rst", mem_addr, 0);
        check_eq("t5_proto_err_rst", proto_err, 0);
        tick(); settle();
        check_eq("t5_req_in_rst", mem_req, 0);
        HRESETN = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_CAFE; settle();
        check_eq("t5_stray_ack", {a_ack, b_ack}, 0);
        check_eq("t5_stray_rdata", b_rdata, 0);
        tick(); settle();
        check_eq("t5_busy_after", BUSY, 0);
        drive_a(1'b0, 3'b010, 20'h00600, 32'h0);
        tick(); settle();
        check_eq("t5_next_req", mem_req, 1);
        check_eq("t5_next_addr", mem_addr, 32'h00600);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h7777_0000; settle();
        check_eq("t5_next_a_ack", a_ack, 1);
        check_eq("t5_next_a_rdata", a_rdata, 32'h7777_0000);
        tick();

        // 64 alternating transactions, next request raised during current WAIT
        for (int i = 0; i < 64; i++) rd_tab[i] = $urandom;
        issue(0);
        for (int i = 0; i < 64; i++) begin
            logic seen;
            int unsigned d;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                tick(); settle();
                if (mem_req) seen = 1'b1;
            end
            check_eq("rnd_grant_seen", seen, 1);
            if (!seen) break;
            check_eq("rnd_addr", mem_addr, rnd_addr(i));
            check_eq("rnd_wdata", mem_wdata, rnd_wdata(i));
            check_eq("rnd_write", mem_write, i[1]);
            d = $urandom_range(1, 8);
            tick();
            if (i < 63) issue(i + 1);
            for (int k = 1; k < int'(d); k++) begin
                settle();
                check_eq("rnd_no_early_ack", {a_ack, b_ack}, 0);
                tick();
            end
            mem_ack = 1'b1; mem_rdata = rd_tab[i]; settle();
            if ((i % 2) == 0) begin
                check_eq("rnd_ack_a", {a_ack, b_ack}, 2'b10);
                check_eq("rnd_rdata_a", a_rdata, rd_tab[i]);
            end else begin
                check_eq("rnd_ack_b", {a_ack, b_ack}, 2'b01);
                check_eq("rnd_rdata_b", b_rdata, rd_tab[i]);
            end
        end
        tick(); tick(); settle();
        check_eq("rnd_drained", {mem_req, BUSY}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsram_port_arbiter.md
Name: lsram_port_arbiter

Overview:
- Two-requester arbiter in front of the large-SRAM control logic.
- Port A is the AHB slave interface (HCLK domain, pulse-style req/ack).
- Port B is the system-side requester: DM waveform/DMA engine.
- Serialises both onto one SRAM command port, returns ack/rdata to the owner, and drives BUSY toward the AHB interface while port B owns or is waiting for the SRAM.

Parameters:
- AHB_DWIDTH, 32, data width of wdata/rdata on all ports
- ADDR_WIDTH, 20, byte address width on all ports
- B_PRIORITY, 1, fixed-priority winner on a simultaneous request when round-robin is compiled out (1 = port B, 0 = port A)

Ports:
- HCLK  in  1  clock
- HRESETN  in  1  asynchronous active-low reset
- a_req  in  1  port A request, single-cycle pulse
- a_write  in  1  port A write (1) / read (0), valid with a_req
- a_size  in  3  port A HSIZE encoding, valid with a_req
- a_addr  in  ADDR_WIDTH  port A address
- a_wdata  in  AHB_DWIDTH  port A write data
- a_ack  out  1  port A completion pulse
- a_rdata  out  AHB_DWIDTH  port A read data, valid with a_ack
- b_req, b_write, b_size, b_addr, b_wdata  in  same as port A  port B command
- b_ack, b_rdata  out  same as port A  port B completion
- mem_req  out  1  SRAM command pulse
- mem_write  out  1  SRAM command write flag
- mem_size  out  3  SRAM command size
- mem_addr  out  ADDR_WIDTH  SRAM command address
- mem_wdata  out  AHB_DWIDTH  SRAM command write data
- mem_ack  in  1  SRAM completion pulse
- mem_rdata  in  AHB_DWIDTH  SRAM read data, valid with mem_ack
- BUSY  out  1  to AHB interface: port B active or pending
- proto_err  out  1  sticky: a request pulse arrived on a port that already had an outstanding request

Behaviour:
- Reset values: all outputs 0; state IDLE; pending flags 0; proto_err 0; RR pointer = port A.
- Per-port pending latch:
  - a_req/b_req pulse captures write/size/addr/wdata into that port's holding register and sets its pending flag.
  - The flag clears on that port's ack.
  - A pulse while the port is already pending or in service is dropped, and proto_err is set.
  - proto_err clears only on reset.
- States:
  - IDLE: if any pending (or a request pulse this cycle), pick a winner and go to ISSUE_A or ISSUE_B.
  - ISSUE_x: mem_req = 1 for exactly one cycle; mem_* driven from the winner's holding register; go to WAIT_x.
  - WAIT_x: mem_* stay stable. On mem_ack: x_ack = 1 and x_rdata = mem_rdata in the same cycle (combinational pass-through), pending_x clears, go to IDLE.
- Latency:
  - Request pulse at cycle N (port idle) -> mem_req at N+1 at the earliest.
  - mem_ack at cycle M -> x_ack at M.
  - Next grant earliest at M+1 (IDLE), mem_req at M+2.
- Arbitration on simultaneous pending: fixed priority per B_PRIORITY; non-winner stays pending and is never dropped.
- A request arriving on the other port during ISSUE/WAIT is latched and served after the current transaction.
- mem_ack while in IDLE or ISSUE is ignored, with no ack to either port.
- a_rdata/b_rdata are 0 when the corresponding ack is 0.
- BUSY:
  - Registered; BUSY = pending_b OR state in {ISSUE_B, WAIT_B}.
  - Asserts the cycle after the b_req pulse.
  - Deasserts the cycle after b_ack unless a new b_req is pending.
- No timeout: WAIT_x holds indefinitely until mem_ack.
- Reset mid-transaction: returns to IDLE immediately and both pending flags clear. A mem_ack arriving after reset deassertion is ignored.

Optional Feature:
- LSRAM_ARB_ROUND_ROBIN_EN
- Defined: simultaneous pending is resolved by a 1-bit RR pointer that flips to the other port after every completed grant. B_PRIORITY is unused.
- Undefined: fixed priority per B_PRIORITY; no pointer register.

Decomposition:
- Shared package lsram_arb_pkg:
  - state encoding: IDLE=3'd0, ISSUE_A=3'd1, WAIT_A=3'd2, ISSUE_B=3'd3, WAIT_B=3'd4
  - HSIZE constants: SZ_BYTE=3'b000, SZ_HALF=3'b001, SZ_WORD=3'b010
  - default widths
- One natural sub-module, lsram_arb_cmd_hold: the per-port holding register with pending flag and proto-error detect. Instantiated twice.

Test Plan:
- Single port-A write, addr=0x00010, wdata=0xDEADBEEF, size=010, mem_ack 3 cycles after mem_req -> mem_req 1 cycle after a_req with exact fields; a_ack same cycle as mem_ack; BUSY stays 0.
- Port-B read, addr=0xFFFFC, mem_rdata=0x12345678 -> BUSY rises the cycle after b_req; b_rdata=0x12345678 with b_ack; BUSY falls the cycle after b_ack.
- a_req and b_req in the same cycle, B_PRIORITY=1, RR off -> B served first, A served second. With RR on: first tie goes to A (pointer reset), next tie goes to B.
- Second a_req while port A is in WAIT_A -> pulse dropped, proto_err=1 held, exactly one a_ack produced.
- HRESETN low during WAIT_B, then a stray mem_ack after release -> outputs and BUSY 0 during reset; no b_ack; next a_req served normally.
- Back-to-back alternating requests over 64 transactions with random mem_ack delay 1-8 -> every request acked exactly once, in grant order, with correct rdata.
